// File: rtl/icache_mem_bridge.sv
// icache_mem_bridge
// Refill bridge between the instruction cache's word-refill port and the
// native single-word memory bus. Each accepted cache request is answered by
// exactly one cache_req_ready pulse. A one-entry buffer holds a prefetched
// copy of the next word in the same line. Two wrapping counters track bus
// traffic and prefetch hits.
//
// Handshakes:
//   cache side: the cache holds cache_req_valid with a stable address until
//     cache_req_ready pulses for one cycle (rdata valid in that cycle) or it
//     abandons the request by dropping valid. A request is only taken while
//     idle and not in a ready-pulse cycle, because valid is still high there.
//   bus side: mem_valid/mem_addr stay stable from rise until the cycle in
//     which mem_ready is high (mem_rdata valid then). A raised request is
//     never withdrawn except by reset. At most one request is outstanding.
module icache_mem_bridge #(
    parameter int BLOCK_SIZE = 4,
    parameter int NUM_BLOCKS = 4,
    parameter int PREFETCH   = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    cache_req_valid,
    input  logic [31:0]             cache_req_addr,
    output logic                    cache_req_ready,
    output logic [8*BLOCK_SIZE-1:0] cache_req_rdata,
    output logic                    mem_valid,
    output logic [31:0]             mem_addr,
    output logic                    mem_instr,
    input  logic                    mem_ready,
    input  logic [8*BLOCK_SIZE-1:0] mem_rdata,
    output logic [31:0]             fetch_count,
    output logic [31:0]             pf_hit_count,
    output logic [1:0]              dbg_state_o
);

    localparam int DW    = 8 * BLOCK_SIZE;
    localparam int IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLOCKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_PREF  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            mem_valid_q, mem_valid_d;
    logic [31:0]     mem_addr_q, mem_addr_d;
    logic            ready_q, ready_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            pf_valid_q, pf_valid_d;
    logic [29:0]     pf_addr_q, pf_addr_d;
    logic [DW-1:0]   pf_data_q, pf_data_d;
    logic [29:0]     req_addr_q, req_addr_d;
    logic            abort_q, abort_d;
    logic [31:0]     fetch_cnt_q, fetch_cnt_d;
    logic [31:0]     hit_cnt_q, hit_cnt_d;

    logic            aborted;
    logic            last_word;
    logic            pf_match;
    logic            unused_addr_bits;

    // Byte offset within the word carries no meaning on this bus.
    assign unused_addr_bits = ^cache_req_addr[1:0];

    // The last word of a line never prefetches, so no fetch crosses a line.
    assign last_word = (NUM_BLOCKS == 1) || (req_addr_q[IDX_W-1:0] == LAST_IDX);
    assign pf_match  = pf_valid_q && (pf_addr_q == cache_req_addr[31:2]);
    // A cache that lets valid fall at any point of the demand fetch has given up.
    assign aborted   = abort_q || !cache_req_valid;

    assign cache_req_ready = ready_q;
    assign cache_req_rdata = rdata_q;
    assign mem_valid       = mem_valid_q;
    assign mem_instr       = mem_valid_q;
    assign mem_addr        = mem_addr_q;
    assign fetch_count     = fetch_cnt_q;
    assign pf_hit_count    = hit_cnt_q;
    assign dbg_state_o     = state_q;

    // State register; reset drops everything, including an in-flight mem_valid.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            ready_q     <= 1'b0;
            rdata_q     <= '0;
            pf_valid_q  <= 1'b0;
            pf_addr_q   <= '0;
            pf_data_q   <= '0;
            req_addr_q  <= '0;
            abort_q     <= 1'b0;
            fetch_cnt_q <= '0;
            hit_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            ready_q     <= ready_d;
            rdata_q     <= rdata_d;
            pf_valid_q  <= pf_valid_d;
            pf_addr_q   <= pf_addr_d;
            pf_data_q   <= pf_data_d;
            req_addr_q  <= req_addr_d;
            abort_q     <= abort_d;
            fetch_cnt_q <= fetch_cnt_d;
            hit_cnt_q   <= hit_cnt_d;
        end
    end

    // Next-state and output logic: hit/miss decision, demand fetch, prefetch.
    always_comb begin
        state_d     = state_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        ready_d     = 1'b0;
        rdata_d     = rdata_q;
        pf_valid_d  = pf_valid_q;
        pf_addr_d   = pf_addr_q;
        pf_data_d   = pf_data_q;
        req_addr_d  = req_addr_q;
        abort_d     = abort_q;
        fetch_cnt_d = fetch_cnt_q;
        hit_cnt_d   = hit_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (cache_req_valid && !ready_q) begin
                    if (pf_match) begin
                        ready_d    = 1'b1;
                        rdata_d    = pf_data_q;
                        pf_valid_d = 1'b0;
                        hit_cnt_d  = hit_cnt_q + 32'd1;
                    end else begin
                        pf_valid_d  = 1'b0;
                        mem_valid_d = 1'b1;
                        mem_addr_d  = {cache_req_addr[31:2], 2'b00};
                        req_addr_d  = cache_req_addr[31:2];
                        state_d     = ST_FETCH;
                    end
                end
            end

            ST_FETCH: begin
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    fetch_cnt_d = fetch_cnt_q + 32'd1;
                    abort_d     = 1'b0;
                    if (aborted) begin
                        state_d = ST_IDLE;
                    end else begin
                        ready_d = 1'b1;
                        rdata_d = mem_rdata;
                        if ((PREFETCH != 0) && !last_word) begin
                            mem_valid_d = 1'b1;
                            mem_addr_d  = {req_addr_q + 30'd1, 2'b00};
                            state_d     = ST_PREF;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end else begin
                    abort_d = aborted;
                end
            end

            ST_PREF: begin
                // Cache requests wait here; they are judged in IDLE afterwards.
                if (mem_ready) begin
                    pf_data_d   = mem_rdata;
                    pf_addr_d   = mem_addr_q[31:2];
                    pf_valid_d  = 1'b1;
                    mem_valid_d = 1'b0;
                    fetch_cnt_d = fetch_cnt_q + 32'd1;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_icache_mem_bridge.sv
// Bench for icache_mem_bridge: two instances (prefetch on / off) behind a
// word-memory responder with configurable wait states, a behavioural model of
// the prefetch buffer and bus traffic, and an expected-address scoreboard.
module tb_icache_mem_bridge;

    localparam int NB = 4;

    logic        clk    = 1'b0;
    logic        resetn = 1'b0;

    logic        cache_req_valid [2] = '{1'b0, 1'b0};
    logic [31:0] cache_req_addr  [2] = '{32'h0, 32'h0};
    logic        cache_req_ready [2];
    logic [31:0] cache_req_rdata [2];
    logic        mem_valid       [2];
    logic [31:0] mem_addr        [2];
    logic        mem_instr       [2];
    logic        mem_ready       [2] = '{1'b0, 1'b0};
    logic [31:0] mem_rdata       [2] = '{32'h0, 32'h0};
    logic [31:0] fetch_count     [2];
    logic [31:0] pf_hit_count    [2];
    logic [1:0]  dbg_state       [2];

    // scoreboard: expected bus addresses in order, per instance
    logic [31:0] exp_q[$];
    logic [31:0] exp_q_np[$];

    // behavioural model
    bit          m_pf_valid [2];
    logic [29:0] m_pf_addr  [2];
    logic [31:0] m_pf_data  [2];
    logic [31:0] m_fetch    [2];
    logic [31:0] m_hit      [2];
    int          mem_wait   [2];
    bit          pf_en      [2] = '{1'b1, 1'b0};

    int          n_cmp = 0;
    int          n_err = 0;

    int          wcnt        [2] = '{0, 0};
    logic        prev_cready [2] = '{1'b0, 1'b0};
    logic        prev_mvalid [2] = '{1'b0, 1'b0};
    logic [31:0] prev_maddr  [2] = '{32'h0, 32'h0};

    // clock
    always #5 clk = ~clk;

    icache_mem_bridge #(.BLOCK_SIZE(4), .NUM_BLOCKS(NB), .PREFETCH(1)) dut (
        .clk(clk), .resetn(resetn),
        .cache_req_valid(cache_req_valid[0]), .cache_req_addr(cache_req_addr[0]),
        .cache_req_ready(cache_req_ready[0]), .cache_req_rdata(cache_req_rdata[0]),
        .mem_valid(mem_valid[0]), .mem_addr(mem_addr[0]), .mem_instr(mem_instr[0]),
        .mem_ready(mem_ready[0]), .mem_rdata(mem_rdata[0]),
        .fetch_count(fetch_count[0]), .pf_hit_count(pf_hit_count[0]),
        .dbg_state_o(dbg_state[0])
    );

    icache_mem_bridge #(.BLOCK_SIZE(4), .NUM_BLOCKS(NB), .PREFETCH(0)) dut_np (
        .clk(clk), .resetn(resetn),
        .cache_req_valid(cache_req_valid[1]), .cache_req_addr(cache_req_addr[1]),
        .cache_req_ready(cache_req_ready[1]), .cache_req_rdata(cache_req_rdata[1]),
        .mem_valid(mem_valid[1]), .mem_addr(mem_addr[1]), .mem_instr(mem_instr[1]),
        .mem_ready(mem_ready[1]), .mem_rdata(mem_rdata[1]),
        .fetch_count(fetch_count[1]), .pf_hit_count(pf_hit_count[1]),
        .dbg_state_o(dbg_state[1])
    );

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return a ^ 32'hA5A5A5A5;
    endfunction

    function automatic void check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pf_valid[d] = 1'b0;
            m_fetch[d]    = 32'd0;
            m_hit[d]      = 32'd0;
        end
    endfunction

    function automatic void expect_bus(input int d, input logic [31:0] a);
        if (d == 0) exp_q.push_back(a);
        else        exp_q_np.push_back(a);
        m_fetch[d] = m_fetch[d] + 32'd1;
    endfunction

    // One cache request as seen from outside: served from the buffer, or a
    // demand fetch followed by a prefetch of the next word inside the line.
    function automatic void model_req(input int d, input logic [31:0] addr,
                                      output logic [31:0] data, output int lat);
        logic [29:0] w;
        w = addr[31:2];
        if (m_pf_valid[d] && m_pf_addr[d] == w) begin
            data          = m_pf_data[d];
            m_pf_valid[d] = 1'b0;
            m_hit[d]      = m_hit[d] + 32'd1;
            lat           = 1;
        end else begin
            m_pf_valid[d] = 1'b0;
            data          = mem_fn({w, 2'b00});
            lat           = 2 + mem_wait[d];
            expect_bus(d, {w, 2'b00});
            if (pf_en[d] && (w % NB) != NB - 1) begin
                expect_bus(d, {w + 30'd1, 2'b00});
                m_pf_valid[d] = 1'b1;
                m_pf_addr[d]  = w + 30'd1;
                m_pf_data[d]  = mem_fn({w + 30'd1, 2'b00});
            end
        end
    endfunction

    function automatic void bus_seen(input int d, input logic [31:0] a);
        int sz;
        logic [31:0] e;
        sz = (d == 0) ? exp_q.size() : exp_q_np.size();
        n_cmp++;
        assert (sz != 0) else begin
            n_err++;
            $error("FAIL bus_unexpected dut=%0d observed=%h expected=none", d, a);
        end
        if (sz != 0) begin
            if (d == 0) e = exp_q.pop_front();
            else        e = exp_q_np.pop_front();
            check(d == 0 ? "bus_addr" : "bus_addr_np", a, e);
        end
    endfunction

    // Memory responder plus protocol monitors, all on the falling edge.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (cache_req_ready[d] === 1'b1) check("ready_single_pulse", 32'(prev_cready[d]), 32'd0);
            if (mem_valid[d] === 1'b1) check("mem_instr", 32'(mem_instr[d]), 32'd1);
            if (mem_valid[d] === 1'b1 && prev_mvalid[d] && !mem_ready[d])
                check("mem_addr_stable", mem_addr[d], prev_maddr[d]);
            prev_cready[d] = cache_req_ready[d];
            prev_mvalid[d] = mem_valid[d];
            prev_maddr[d]  = mem_addr[d];

            if (!resetn) begin
                mem_ready[d] = 1'b0;
                wcnt[d]      = 0;
            end else begin
                if (mem_ready[d]) begin
                    mem_ready[d] = 1'b0;
                    wcnt[d]      = 0;
                end
                if (mem_valid[d] === 1'b1) begin
                    if (wcnt[d] >= mem_wait[d]) begin
                        mem_ready[d] = 1'b1;
                        mem_rdata[d] = mem_fn(mem_addr[d]);
                        bus_seen(d, mem_addr[d]);
                    end else begin
                        wcnt[d]++;
                    end
                end else begin
                    wcnt[d] = 0;
                end
            end
        end
    end

    task automatic chk_reset_outputs(input int d, input string tag);
        check({tag, "_ready"},   32'(cache_req_ready[d]), 32'd0);
        check({tag, "_rdata"},   cache_req_rdata[d],      32'd0);
        check({tag, "_mvalid"},  32'(mem_valid[d]),       32'd0);
        check({tag, "_maddr"},   mem_addr[d],             32'd0);
        check({tag, "_minstr"},  32'(mem_instr[d]),       32'd0);
        check({tag, "_fetches"}, fetch_count[d],          32'd0);
        check({tag, "_hits"},    pf_hit_count[d],         32'd0);
    endtask

    task automatic chk_counters(input int d, input string tag);
        check({tag, "_fetch_count"},  fetch_count[d],  m_fetch[d]);
        check({tag, "_pf_hit_count"}, pf_hit_count[d], m_hit[d]);
    endtask

    task automatic wait_bus_idle(input int d);
        int n;
        n = 0;
        while (mem_valid[d] !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("bus_idle_in_time", 32'(mem_valid[d]), 32'd0);
    endtask

    task automatic do_reset();
        wait_bus_idle(0);
        wait_bus_idle(1);
        check("bus_leftover", 32'(exp_q.size()), 32'd0);
        check("bus_leftover_np", 32'(exp_q_np.size()), 32'd0);
        resetn = 1'b0;
        cache_req_valid[0] = 1'b0;
        cache_req_valid[1] = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs(0, "rst");
        chk_reset_outputs(1, "rst_np");
        resetn = 1'b1;
        model_reset();
    endtask

    // Issue one request, hold valid through the ready cycle's closing edge,
    // then drop it. Latency counts rising edges from raise to ready.
    task automatic do_req(input int d, input logic [31:0] addr, input bit chk_lat, input string tag);
        logic [31:0] edata;
        int elat;
        int lat;
        bit got;
        wait_bus_idle(d);
        model_req(d, addr, edata, elat);
        cache_req_valid[d] = 1'b1;
        cache_req_addr[d]  = addr;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 60) begin
            @(negedge clk);
            lat++;
            if (cache_req_ready[d] === 1'b1) got = 1'b1;
        end
        check({tag, "_ready_seen"}, 32'(got), 32'd1);
        if (got) begin
            check({tag, "_rdata"}, cache_req_rdata[d], edata);
            if (chk_lat) check({tag, "_latency"}, 32'(lat), 32'(elat));
        end
        @(negedge clk);
        cache_req_valid[d] = 1'b0;
    endtask

    // Issue a request while a prefetch is still on the bus: it must be held
    // until the bus goes idle, then served with the usual idle latency.
    task automatic req_during_pref(input logic [31:0] addr, input string tag);
        logic [31:0] edata;
        int elat;
        int k;
        int idle_k;
        int rdy_k;
        check({tag, "_pref_pending"}, 32'(mem_valid[0]), 32'd1);
        model_req(0, addr, edata, elat);
        cache_req_valid[0] = 1'b1;
        cache_req_addr[0]  = addr;
        idle_k = -1;
        rdy_k  = -1;
        k = 0;
        while (rdy_k < 0 && k < 80) begin
            @(negedge clk);
            k++;
            if (mem_valid[0] === 1'b0 && idle_k < 0) idle_k = k;
            if (cache_req_ready[0] === 1'b1) rdy_k = k;
        end
        check({tag, "_ready_seen"}, 32'(rdy_k >= 0), 32'd1);
        check({tag, "_held_latency"}, 32'(rdy_k - idle_k), 32'(elat));
        check({tag, "_rdata"}, cache_req_rdata[0], edata);
        @(negedge clk);
        cache_req_valid[0] = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] a;
        bit seen;
        int n;

        mem_wait[0] = 0;
        mem_wait[1] = 0;
        model_reset();

        // reset values
        repeat (2) @(negedge clk);
        chk_reset_outputs(0, "por");
        chk_reset_outputs(1, "por_np");
        resetn = 1'b1;
        @(negedge clk);

        // 1: asynchronous reset in the middle of a demand fetch
        mem_wait[0] = 5;
        cache_req_valid[0] = 1'b1;
        cache_req_addr[0]  = 32'h80;
        @(negedge clk);
        check("t1_mvalid_before", 32'(mem_valid[0]), 32'd1);
        check("t1_maddr_before", mem_addr[0], 32'h80);
        #2;
        resetn = 1'b0;
        cache_req_valid[0] = 1'b0;
        #1;
        chk_reset_outputs(0, "t1_async");
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        model_reset();
        mem_wait[0] = 0;
        do_req(0, 32'h100, 1'b1, "t1_fresh");
        wait_bus_idle(0);
        chk_counters(0, "t1");

        // 2: line refill with prefetch, zero-wait memory
        do_reset();
        do_req(0, 32'h200, 1'b1, "t2_w0");
        do_req(0, 32'h204, 1'b1, "t2_w1_hit");
        do_req(0, 32'h208, 1'b1, "t2_w2");
        do_req(0, 32'h20C, 1'b1, "t2_w3_hit");
        wait_bus_idle(0);
        check("t2_fetch_count", fetch_count[0], 32'd4);
        check("t2_pf_hit_count", pf_hit_count[0], 32'd2);
        // a demand miss on the last word of a line must not prefetch the next line
        do_req(0, 32'h30C, 1'b1, "t2_last_word");
        check("t2_no_cross_line", 32'(mem_valid[0]), 32'd0);
        chk_counters(0, "t2");

        // 3: pass-through instance, same refill
        do_req(1, 32'h200, 1'b1, "t3_w0");
        do_req(1, 32'h204, 1'b1, "t3_w1");
        do_req(1, 32'h208, 1'b1, "t3_w2");
        do_req(1, 32'h20C, 1'b1, "t3_w3");
        wait_bus_idle(1);
        check("t3_fetch_count", fetch_count[1], 32'd4);
        check("t3_pf_hit_count", pf_hit_count[1], 32'd0);

        // 4: abandoned request, memory waits 5 cycles
        do_reset();
        mem_wait[0] = 5;
        m_pf_valid[0] = 1'b0;
        expect_bus(0, 32'h300);
        cache_req_valid[0] = 1'b1;
        cache_req_addr[0]  = 32'h300;
        repeat (2) @(negedge clk);
        cache_req_valid[0] = 1'b0;
        seen = 1'b0;
        n = 0;
        while (mem_valid[0] !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
            if (cache_req_ready[0] === 1'b1) seen = 1'b1;
        end
        @(negedge clk);
        if (cache_req_ready[0] === 1'b1) seen = 1'b1;
        check("t4_no_ready_pulse", 32'(seen), 32'd0);
        check("t4_no_prefetch", 32'(mem_valid[0]), 32'd0);
        mem_wait[0] = 0;
        do_req(0, 32'h304, 1'b1, "t4_next_miss");
        wait_bus_idle(0);
        chk_counters(0, "t4");

        // 5: request for the word being prefetched is held, then hits
        mem_wait[0] = 3;
        do_req(0, 32'h400, 1'b1, "t5_demand");
        req_during_pref(32'h404, "t5_hit");
        // another line while a prefetch is in flight: buffer is dropped, miss
        do_req(0, 32'h408, 1'b1, "t5_demand2");
        req_during_pref(32'h500, "t5_other");
        do_req(0, 32'h40C, 1'b1, "t5_after");
        wait_bus_idle(0);
        chk_counters(0, "t5");

        // randomized traffic, mostly sequential so the buffer is exercised
        do_reset();
        a = 32'h1000;
        for (int i = 0; i < 60; i++) begin
            mem_wait[0] = $urandom_range(0, 3);
            if ($urandom_range(0, 2) != 0) a = a + 32'd4;
            else a = 32'h1000 + (32'($urandom_range(0, 63)) << 2);
            a[1:0] = 2'($urandom_range(0, 3));
            do_req(0, a, 1'b1, "rand");
        end
        for (int i = 0; i < 20; i++) begin
            mem_wait[1] = $urandom_range(0, 3);
            a = 32'h2000 + (32'($urandom_range(0, 31)) << 2);
            do_req(1, a, 1'b1, "rand_np");
        end
        wait_bus_idle(0);
        wait_bus_idle(1);
        chk_counters(0, "rand");
        chk_counters(1, "rand_np");
        check("final_bus_leftover", 32'(exp_q.size()), 32'd0);
        check("final_bus_leftover_np", 32'(exp_q_np.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
